// File: rtl/csi2tx_ldl_lane_sched_if.sv
// Scheduler-side bundle between the register/PHY wrapper and csi2tx_ldl_lane_sched.
// master drives configuration and per-instance status; slave is the scheduler.
interface csi2tx_ldl_lane_sched_if #(
    parameter int HS_EXIT_W = 8,
    parameter int PKT_CNT_W = 16
);
    logic [2:0]           cfg_lane_cnt;
    logic [HS_EXIT_W-1:0] cfg_hs_exit_cnt;
    logic                 sched_en;
    logic                 csi_byte_fifo_empty;
    logic                 forcetxstopmode;
    logic [7:0]           stopstate_lane;
    logic [3:0]           ldl_tx_done;
    logic [3:0]           ldl_hs_exit_en;
    logic [3:0]           ldl_fifo_rd_en;

    logic [3:0]           lane_en;
    logic                 enable_hs_transmission;
    logic                 fifo_rd_en;
    logic                 hs_exit_cnt_expired;
    logic                 stop_state_dl;
    logic [7:0]           active_lane_mask;
    logic                 cfg_err;
    logic                 busy;
    logic [PKT_CNT_W-1:0] pkt_cnt;

    modport master (
        output cfg_lane_cnt, cfg_hs_exit_cnt, sched_en, csi_byte_fifo_empty,
               forcetxstopmode, stopstate_lane, ldl_tx_done, ldl_hs_exit_en,
               ldl_fifo_rd_en,
        input  lane_en, enable_hs_transmission, fifo_rd_en, hs_exit_cnt_expired,
               stop_state_dl, active_lane_mask, cfg_err, busy, pkt_cnt
    );

    modport slave (
        input  cfg_lane_cnt, cfg_hs_exit_cnt, sched_en, csi_byte_fifo_empty,
               forcetxstopmode, stopstate_lane, ldl_tx_done, ldl_hs_exit_en,
               ldl_fifo_rd_en,
        output lane_en, enable_hs_transmission, fifo_rd_en, hs_exit_cnt_expired,
               stop_state_dl, active_lane_mask, cfg_err, busy, pkt_cnt
    );
endinterface

// File: rtl/csi2tx_ldl_lane_sched.sv
// Selects one LDL instance per packet, gates HS start, runs the shared HS-exit countdown.
// IDLE->LATCH->ARM->RUN takes 3 edges; FIFO read-enable and stop-state muxes are combinational.
module csi2tx_ldl_lane_sched #(
    parameter int HS_EXIT_W = 8,
    parameter int PKT_CNT_W = 16
) (
    input  logic                     txbyteclkhs,
    input  logic                     txbyteclkhs_rst_n,
    csi2tx_ldl_lane_sched_if.slave   sif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_EXIT  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           lane_en_q, lane_en_d;
    logic [7:0]           mask_q, mask_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 en_hs_q, en_hs_d;
    logic [HS_EXIT_W-1:0] hs_cnt_q, hs_cnt_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                 tx_done_prev_q;
    logic                 exit_seen_q, exit_seen_d;

    logic                 sel_tx_done;
    logic                 sel_hs_exit_en;
    logic                 sel_fifo_rd_en;
    logic                 tx_done_rise;

    logic                 dec_legal;
    logic [3:0]           dec_lane_en;
    logic [7:0]           dec_mask;

    // Only the one-hot selected instance is ever observed.
    assign sel_tx_done    = |(sif.ldl_tx_done    & lane_en_q);
    assign sel_hs_exit_en = |(sif.ldl_hs_exit_en & lane_en_q);
    assign sel_fifo_rd_en = |(sif.ldl_fifo_rd_en & lane_en_q);
    assign tx_done_rise   = sel_tx_done & ~tx_done_prev_q;

    always_comb begin
        dec_legal   = 1'b1;
        dec_lane_en = 4'b0001;
        dec_mask    = 8'h01;
        case (sif.cfg_lane_cnt)
            3'd0: begin
                dec_lane_en = 4'b0001;
                dec_mask    = 8'h01;
            end
            3'd1: begin
                dec_lane_en = 4'b0010;
                dec_mask    = 8'h03;
            end
            3'd3: begin
                dec_lane_en = 4'b0100;
                dec_mask    = 8'h0F;
            end
            3'd7: begin
                dec_lane_en = 4'b1000;
                dec_mask    = 8'hFF;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        lane_en_d   = lane_en_q;
        mask_d      = mask_q;
        cfg_err_d   = cfg_err_q;
        pkt_cnt_d   = pkt_cnt_q;
        exit_seen_d = 1'b0;

        if (sif.forcetxstopmode) begin
            // Force wins over everything, including a same-cycle tx_done edge.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sif.sched_en && !sif.csi_byte_fifo_empty) begin
                        state_d = ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (dec_legal) begin
                        lane_en_d = dec_lane_en;
                        mask_d    = dec_mask;
                        state_d   = ST_ARM;
                    end else begin
                        cfg_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (tx_done_rise) begin
                        pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
                        state_d   = ST_EXIT;
                    end
                end
                ST_EXIT: begin
                    // Leave only after the instance has raised and then dropped its exit enable.
                    exit_seen_d = exit_seen_q | sel_hs_exit_en;
                    if (exit_seen_q && !sel_hs_exit_en) begin
                        exit_seen_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        en_hs_d = (state_d == ST_RUN);
    end

    always_comb begin
        hs_cnt_d = hs_cnt_q;
        if (sif.forcetxstopmode || !sel_hs_exit_en) begin
            hs_cnt_d = sif.cfg_hs_exit_cnt;
        end else if (hs_cnt_q != '0) begin
            hs_cnt_d = hs_cnt_q - HS_EXIT_W'(1);
        end
    end

    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            state_q        <= ST_IDLE;
            lane_en_q      <= 4'b0001;
            mask_q         <= 8'h01;
            cfg_err_q      <= 1'b0;
            en_hs_q        <= 1'b0;
            hs_cnt_q       <= '0;
            pkt_cnt_q      <= '0;
            tx_done_prev_q <= 1'b0;
            exit_seen_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lane_en_q      <= lane_en_d;
            mask_q         <= mask_d;
            cfg_err_q      <= cfg_err_d;
            en_hs_q        <= en_hs_d;
            hs_cnt_q       <= hs_cnt_d;
            pkt_cnt_q      <= pkt_cnt_d;
            tx_done_prev_q <= sel_tx_done;
            exit_seen_q    <= exit_seen_d;
        end
    end

    assign sif.lane_en                = lane_en_q;
    assign sif.active_lane_mask       = mask_q;
    assign sif.enable_hs_transmission = en_hs_q;
    assign sif.fifo_rd_en             = sel_fifo_rd_en;
    assign sif.hs_exit_cnt_expired    = sel_hs_exit_en & (hs_cnt_q == '0);
    // Inactive lanes are treated as stopped.
    assign sif.stop_state_dl          = &(sif.stopstate_lane | ~mask_q);
    assign sif.cfg_err                = cfg_err_q;
    assign sif.busy                   = (state_q != ST_IDLE);
    assign sif.pkt_cnt                = pkt_cnt_q;

endmodule

// File: tb/tb_csi2tx_ldl_lane_sched.sv
// Directed per-cycle vector table plus packet sequences for back-to-back and counter wrap.
module tb_csi2tx_ldl_lane_sched;

    logic txbyteclkhs;
    logic txbyteclkhs_rst_n;

    csi2tx_ldl_lane_sched_if #(.HS_EXIT_W(8), .PKT_CNT_W(16)) m_if ();
    csi2tx_ldl_lane_sched_if #(.HS_EXIT_W(8), .PKT_CNT_W(3))  w_if ();

    csi2tx_ldl_lane_sched #(.HS_EXIT_W(8), .PKT_CNT_W(16)) u_dut (
        .txbyteclkhs       (txbyteclkhs),
        .txbyteclkhs_rst_n (txbyteclkhs_rst_n),
        .sif               (m_if)
    );

    // Narrow-counter copy sees identical stimulus; it exposes the wrap cheaply.
    csi2tx_ldl_lane_sched #(.HS_EXIT_W(8), .PKT_CNT_W(3)) u_wrap (
        .txbyteclkhs       (txbyteclkhs),
        .txbyteclkhs_rst_n (txbyteclkhs_rst_n),
        .sif               (w_if)
    );

    assign w_if.cfg_lane_cnt        = m_if.cfg_lane_cnt;
    assign w_if.cfg_hs_exit_cnt     = m_if.cfg_hs_exit_cnt;
    assign w_if.sched_en            = m_if.sched_en;
    assign w_if.csi_byte_fifo_empty = m_if.csi_byte_fifo_empty;
    assign w_if.forcetxstopmode     = m_if.forcetxstopmode;
    assign w_if.stopstate_lane      = m_if.stopstate_lane;
    assign w_if.ldl_tx_done         = m_if.ldl_tx_done;
    assign w_if.ldl_hs_exit_en      = m_if.ldl_hs_exit_en;
    assign w_if.ldl_fifo_rd_en      = m_if.ldl_fifo_rd_en;

    initial txbyteclkhs = 1'b0;
    always #5 txbyteclkhs = ~txbyteclkhs;

    typedef struct packed {
        logic [2:0]  cfg;
        logic [7:0]  hsc;
        logic        sen;
        logic        emp;
        logic        frc;
        logic [7:0]  stop;
        logic [3:0]  done;
        logic [3:0]  hse;
        logic [3:0]  rd;
        logic [3:0]  x_lane;
        logic [7:0]  x_mask;
        logic        x_en;
        logic        x_rd;
        logic        x_exp;
        logic        x_stop;
        logic        x_err;
        logic        x_busy;
        logic [15:0] x_pkt;
    } vec_t;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_pkt = 0;
    logic [31:0] exp_pkt_v;

    task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task cyc();
        @(posedge txbyteclkhs);
        #1;
    endtask

    task apply(input vec_t v);
        m_if.cfg_lane_cnt        = v.cfg;
        m_if.cfg_hs_exit_cnt     = v.hsc;
        m_if.sched_en            = v.sen;
        m_if.csi_byte_fifo_empty = v.emp;
        m_if.forcetxstopmode     = v.frc;
        m_if.stopstate_lane      = v.stop;
        m_if.ldl_tx_done         = v.done;
        m_if.ldl_hs_exit_en      = v.hse;
        m_if.ldl_fifo_rd_en      = v.rd;
    endtask

    task compare(input int row, input vec_t v);
        string p;
        p = $sformatf("row%0d", row);
        chk({p, ".lane_en"},   32'(m_if.lane_en),                v.x_lane);
        chk({p, ".mask"},      32'(m_if.active_lane_mask),       v.x_mask);
        chk({p, ".en_hs"},     32'(m_if.enable_hs_transmission), v.x_en);
        chk({p, ".fifo_rd"},   32'(m_if.fifo_rd_en),             v.x_rd);
        chk({p, ".expired"},   32'(m_if.hs_exit_cnt_expired),    v.x_exp);
        chk({p, ".stop_dl"},   32'(m_if.stop_state_dl),          v.x_stop);
        chk({p, ".cfg_err"},   32'(m_if.cfg_err),                v.x_err);
        chk({p, ".busy"},      32'(m_if.busy),                   v.x_busy);
        chk({p, ".pkt_cnt"},   32'(m_if.pkt_cnt),                v.x_pkt);
    endtask

    // One 2-lane packet; keep=1 leaves sched_en high so the next packet follows immediately.
    task pkt(input logic keep);
        cyc();
        m_if.sched_en = 1'b1; m_if.csi_byte_fifo_empty = 1'b0; m_if.cfg_lane_cnt = 3'd1;
        m_if.ldl_tx_done = 4'h0; m_if.ldl_hs_exit_en = 4'h0;
        @(negedge txbyteclkhs); chk("pkt.idle_busy", 32'(m_if.busy), 0);
        cyc();
        @(negedge txbyteclkhs); chk("pkt.latch_busy", 32'(m_if.busy), 1);
        cyc();
        @(negedge txbyteclkhs); chk("pkt.arm_lane", 32'(m_if.lane_en), 4'b0010);
        chk("pkt.arm_en", 32'(m_if.enable_hs_transmission), 0);
        cyc();
        m_if.sched_en = keep;
        @(negedge txbyteclkhs); chk("pkt.run_en", 32'(m_if.enable_hs_transmission), 1);
        cyc();
        m_if.ldl_tx_done = 4'b0010;
        @(negedge txbyteclkhs); chk("pkt.run_en2", 32'(m_if.enable_hs_transmission), 1);
        cyc();
        m_if.ldl_tx_done = 4'h0; m_if.ldl_hs_exit_en = 4'b0010;
        exp_pkt++;
        exp_pkt_v = 32'(exp_pkt);
        @(negedge txbyteclkhs); chk("pkt.exit_en", 32'(m_if.enable_hs_transmission), 0);
        chk("pkt.cnt16", 32'(m_if.pkt_cnt), {16'h0, exp_pkt_v[15:0]});
        chk("pkt.cnt3",  32'(w_if.pkt_cnt), {29'h0, exp_pkt_v[2:0]});
        cyc();
        m_if.ldl_hs_exit_en = 4'h0;
        @(negedge txbyteclkhs); chk("pkt.exit_busy", 32'(m_if.busy), 1);
        if (!keep) begin
            cyc();
            @(negedge txbyteclkhs); chk("pkt.drop_idle0", 32'(m_if.busy), 0);
            cyc();
            @(negedge txbyteclkhs); chk("pkt.drop_idle1", 32'(m_if.busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // cfg  hsc   sen emp frc stop   done  hse   rd  | lane  mask  en rd exp stp err bsy pkt
        vq.push_back('{3'd1,8'd5,Y,N,N,8'h00,4'h0,4'h0,4'h0, 4'h1,8'h01,N,N,N,N,N,N,16'd0}); // 0 IDLE
        vq.push_back('{3'd1,8'd5,Y,N,N,8'h00,4'h0,4'h0,4'h0, 4'h1,8'h01,N,N,N,N,N,Y,16'd0}); // 1 LATCH
        vq.push_back('{3'd1,8'd5,N,N,N,8'h03,4'h0,4'h0,4'h0, 4'h2,8'h03,N,N,N,Y,N,Y,16'd0}); // 2 ARM
        vq.push_back('{3'd1,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h1, 4'h2,8'h03,Y,N,N,N,N,Y,16'd0}); // 3 RUN
        vq.push_back('{3'd1,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h2, 4'h2,8'h03,Y,Y,N,N,N,Y,16'd0}); // 4
        vq.push_back('{3'd1,8'd5,N,N,N,8'h00,4'h1,4'h0,4'h0, 4'h2,8'h03,Y,N,N,N,N,Y,16'd0}); // 5 wrong done
        vq.push_back('{3'd1,8'd5,N,N,N,8'h00,4'h2,4'h0,4'h0, 4'h2,8'h03,Y,N,N,N,N,Y,16'd0}); // 6 done rise
        vq.push_back('{3'd1,8'd5,N,N,N,8'h00,4'h2,4'h0,4'h0, 4'h2,8'h03,N,N,N,N,N,Y,16'd1}); // 7 EXIT
        vq.push_back('{3'd1,8'd5,N,N,N,8'h00,4'h2,4'h2,4'h0, 4'h2,8'h03,N,N,N,N,N,Y,16'd1}); // 8
        vq.push_back('{3'd1,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h2,8'h03,N,N,N,N,N,Y,16'd1}); // 9
        vq.push_back('{3'd1,8'd5,Y,Y,N,8'h00,4'h0,4'h0,4'h0, 4'h2,8'h03,N,N,N,N,N,N,16'd1}); // 10 empty
        vq.push_back('{3'd2,8'd5,Y,N,N,8'h00,4'h0,4'h0,4'h0, 4'h2,8'h03,N,N,N,N,N,N,16'd1}); // 11
        vq.push_back('{3'd2,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h2,8'h03,N,N,N,N,N,Y,16'd1}); // 12 LATCH bad
        vq.push_back('{3'd3,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h2,8'h03,N,N,N,N,Y,N,16'd1}); // 13
        vq.push_back('{3'd3,8'd5,Y,N,N,8'h00,4'h0,4'h0,4'h0, 4'h2,8'h03,N,N,N,N,Y,N,16'd1}); // 14
        vq.push_back('{3'd3,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h2,8'h03,N,N,N,N,Y,Y,16'd1}); // 15 LATCH
        vq.push_back('{3'd3,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h4,8'h0F,N,N,N,N,Y,Y,16'd1}); // 16 ARM
        vq.push_back('{3'd3,8'd5,N,N,N,8'h00,4'h4,4'h0,4'h0, 4'h4,8'h0F,Y,N,N,N,Y,Y,16'd1}); // 17 RUN
        vq.push_back('{3'd3,8'd5,N,N,N,8'h00,4'h4,4'h4,4'h0, 4'h4,8'h0F,N,N,N,N,Y,Y,16'd2}); // 18 en #1
        for (int k = 0; k < 4; k++)                                                          // en #2..#5
            vq.push_back('{3'd3,8'd5,N,N,N,8'h00,4'h0,4'h4,4'h0, 4'h4,8'h0F,N,N,N,N,Y,Y,16'd2});
        vq.push_back('{3'd3,8'd5,N,N,N,8'h00,4'h0,4'h4,4'h0, 4'h4,8'h0F,N,N,Y,N,Y,Y,16'd2}); // 23 en #6
        vq.push_back('{3'd3,8'd5,N,N,N,8'h00,4'h0,4'h4,4'h0, 4'h4,8'h0F,N,N,Y,N,Y,Y,16'd2}); // 24
        vq.push_back('{3'd3,8'd0,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h4,8'h0F,N,N,N,N,Y,Y,16'd2}); // 25
        vq.push_back('{3'd3,8'd0,N,N,N,8'h00,4'h0,4'h4,4'h0, 4'h4,8'h0F,N,N,Y,N,Y,N,16'd2}); // 26 cnt 0
        vq.push_back('{3'd3,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h4,8'h0F,N,N,N,N,Y,N,16'd2}); // 27
        vq.push_back('{3'd7,8'd5,Y,N,N,8'h0F,4'h0,4'h0,4'h0, 4'h4,8'h0F,N,N,N,Y,Y,N,16'd2}); // 28
        vq.push_back('{3'd7,8'd5,N,N,N,8'h0F,4'h0,4'h0,4'h0, 4'h4,8'h0F,N,N,N,Y,Y,Y,16'd2}); // 29 LATCH
        vq.push_back('{3'd7,8'd5,N,N,N,8'h7F,4'h0,4'h0,4'h0, 4'h8,8'hFF,N,N,N,N,Y,Y,16'd2}); // 30 ARM
        vq.push_back('{3'd0,8'd5,N,N,N,8'hFF,4'h0,4'h0,4'h0, 4'h8,8'hFF,Y,N,N,Y,Y,Y,16'd2}); // 31 RUN
        vq.push_back('{3'd0,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h8, 4'h8,8'hFF,Y,Y,N,N,Y,Y,16'd2}); // 32
        vq.push_back('{3'd0,8'd5,N,N,N,8'h00,4'h8,4'h0,4'h0, 4'h8,8'hFF,Y,N,N,N,Y,Y,16'd2}); // 33
        vq.push_back('{3'd0,8'd5,N,N,N,8'h00,4'h0,4'h8,4'h0, 4'h8,8'hFF,N,N,N,N,Y,Y,16'd3}); // 34 EXIT
        vq.push_back('{3'd0,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h8,8'hFF,N,N,N,N,Y,Y,16'd3}); // 35
        vq.push_back('{3'd0,8'd5,Y,N,N,8'h00,4'h0,4'h0,4'h0, 4'h8,8'hFF,N,N,N,N,Y,N,16'd3}); // 36 IDLE
        vq.push_back('{3'd0,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h8,8'hFF,N,N,N,N,Y,Y,16'd3}); // 37 LATCH
        vq.push_back('{3'd0,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h1,8'h01,N,N,N,N,Y,Y,16'd3}); // 38 ARM
        vq.push_back('{3'd0,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h1,8'h01,Y,N,N,N,Y,Y,16'd3}); // 39 RUN
        vq.push_back('{3'd0,8'd5,N,N,Y,8'h00,4'h1,4'h0,4'h0, 4'h1,8'h01,Y,N,N,N,Y,Y,16'd3}); // 40 force
        vq.push_back('{3'd0,8'd5,N,N,N,8'h00,4'h1,4'h0,4'h0, 4'h1,8'h01,N,N,N,N,Y,N,16'd3}); // 41 IDLE
        vq.push_back('{3'd0,8'd5,N,N,N,8'h00,4'h0,4'h0,4'h0, 4'h1,8'h01,N,N,N,N,Y,N,16'd3}); // 42

        txbyteclkhs_rst_n = 1'b0;
        apply('{3'd1,8'd5,N,Y,N,8'h00,4'h0,4'h0,4'h0, 4'h1,8'h01,N,N,N,N,N,N,16'd0});
        repeat (2) @(negedge txbyteclkhs);
        compare(-1, '{3'd1,8'd5,N,Y,N,8'h00,4'h0,4'h0,4'h0, 4'h1,8'h01,N,N,N,N,N,N,16'd0});
        chk("reset.wrap_cnt", 32'(w_if.pkt_cnt), 0);
        txbyteclkhs_rst_n = 1'b1;

        foreach (vq[i]) begin
            cyc();
            apply(vq[i]);
            @(negedge txbyteclkhs);
            compare(i, vq[i]);
        end

        exp_pkt = 3;
        pkt(1'b1);
        pkt(1'b1);
        pkt(1'b1);
        pkt(1'b0);
        pkt(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
